// File: rtl/ctrl_pkg.sv
// Shared control-bundle types for the pipelined CPU.
// The ALU control word carried through the execute-side delay line.
package ctrl_pkg;

    typedef struct packed {
        logic [2:0] ALUCntrl;
        logic       FlagE;
        logic       FwdALU;
        logic       ShiftDir;
        logic       ShiftToALUB;
        logic [5:0] Shamt;
    } alu_ctrl_t;

    localparam int unsigned ALU_CTRL_W = $bits(alu_ctrl_t);

    localparam alu_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_delay_stage.sv
// One register stage of the control delay line: valid bit plus control word.
// Holds, advances, or turns into an all-zero bubble depending on hold/kill/flush.
module ctrl_delay_stage
    import ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_CTRL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             hold,
    input  logic             kill,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_hold,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Every path that does not explicitly keep or load an entry yields a bubble.
    always_comb begin
        valid_d = 1'b0;
        data_d  = '0;
        if (flush) begin
            valid_d = 1'b0;
        end else if (hold) begin
            if (valid_q && !kill) begin
                valid_d = 1'b1;
                data_d  = data_q;
            end
        end else if (!up_hold && up_valid) begin
            valid_d = 1'b1;
            data_d  = up_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/ctrl_delay_line.sv
// Stallable, flushable delay line carrying decoded control words DEPTH cycles.
// Builds the upstream-propagating hold chain and exposes every stage.
module ctrl_delay_line
    import ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_CTRL_W,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [DEPTH-1:0]       stall,
    input  logic [DEPTH-1:0]       kill,
    input  logic                   flush,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [CntW-1:0]        count
);

    logic [DEPTH-1:0] hold;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        // A stall anywhere downstream freezes this stage too.
        assign hold[i] = |stall[DEPTH-1:i];

        if (i == 0) begin : g_head
            ctrl_delay_stage #(
                .WIDTH(WIDTH)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .flush   (flush),
                .hold    (hold[i]),
                .kill    (kill[i]),
                .up_valid(in_valid),
                .up_data (in_data),
                .up_hold (1'b0),
                .valid   (stage_valid[i]),
                .data    (stage_data[i*WIDTH +: WIDTH])
            );
        end else begin : g_body
            ctrl_delay_stage #(
                .WIDTH(WIDTH)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .flush   (flush),
                .hold    (hold[i]),
                .kill    (kill[i]),
                .up_valid(stage_valid[i-1] & ~kill[i-1]),
                .up_data (stage_data[(i-1)*WIDTH +: WIDTH]),
                .up_hold (hold[i-1]),
                .valid   (stage_valid[i]),
                .data    (stage_data[i*WIDTH +: WIDTH])
            );
        end
    end

    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[(DEPTH-1)*WIDTH +: WIDTH];

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CntW'(stage_valid[i]);
        end
    end

endmodule
